fp_addsub_seq: RTL and testbench
================================

# fp_addsub_seq

Sequential bfloat16 add/subtract engine with valid/ready handshakes on both sides. It accepts one operand pair plus an operation select. It then runs an iterative align / add / normalize / round state machine and holds the IEEE-754-style result, its class and its exception flags until the consumer accepts them. It is the multi-cycle, back-pressurable counterpart of the combinational adder: a stimulus or sequencer block is the initiator, and this block is the responder.

## Interface
- NEXP, 8, exponent width (bias 2^(NEXP-1)-1)
- NSIG, 7, stored significand width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  engine can accept; high only in IDLE and while rst is low
- a, b  input  NEXP+NSIG+1  operands {sign, exp, sig}
- op  input  1  0 = a+b, 1 = a-b
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  NEXP+NSIG+1  rounded result
- res_class  output  5  one-hot {nan, inf, zero, subnormal, normal} of result
- exception  output  4  {invalid, overflow, underflow, inexact}

## Operation
- **Capture:** handshake occurs when in_valid && in_ready, at edge E0. a, b and op are registered. For op=1, b's sign is inverted.
- **States:** IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE.
- **UNPACK:**
  - Classify both operands.
  - Special cases go straight to DONE:
    - Any NaN gives canonical qNaN {0, all-ones, 1000…0}. invalid is set if either operand is a signalling NaN.
    - inf + (-inf) gives qNaN with invalid set.
    - Any other inf gives that inf.
  - Otherwise, insert the hidden bit and append guard, round and sticky bits. Go to ALIGN if the exponents differ, else to ADD.
- **ALIGN:**
  - Each cycle shifts the smaller-exponent significand right 1 bit and ORs the shifted-out bit into sticky.
  - k = min(exp diff, NSIG+4) cycles. Once the diff exceeds NSIG+4, the whole significand is folded into sticky on the last cycle.
- **ADD:**
  - Add on equal effective signs, otherwise subtract smaller magnitude from larger. Result sign is that of the larger magnitude.
  - A carry-out is right-shifted here, with exponent +1 and no extra cycle.
  - An exact-zero difference yields +0.
- **NORM:** shift left 1 bit per cycle until the hidden bit is 1, decrementing the exponent. This takes m cycles (m=0 allowed), stopping at minimum exponent.
- **ROUND:**
  - Round to nearest, ties to even. A rounding carry renormalizes in the same cycle.
  - Exponent overflow gives signed inf with overflow and inexact set.
  - inexact = guard|round|sticky.
- **DONE:**
  - result, res_class and exception are registered, and out_valid=1.
  - All outputs stay stable until out_valid && out_ready, then the state returns to IDLE.
- **Reset** (any state, any time): state=IDLE, out_valid=0, result=0, res_class=0, exception=0. Any in-flight operation is discarded with no output.

## Timing
- in_ready is combinational from state; it is 0 from E0 until the cycle after the output handshake.
- Latency L = edges from E0 until out_valid is high:
  - special cases: L=1
  - all other operands: L = 3+k+m
- Worst case: L = 3+(NSIG+4)+(NSIG+3) = 24 at defaults.
- Output handshake at edge Ex returns the block to IDLE, so in_ready=1 in the cycle after Ex. There is no overlap of operations.
- out_ready high while out_valid is low is ignored.

## Configuration
- FP_SUBNORMAL_EN defined:
  - Subnormal inputs unpack with hidden bit 0 and exponent 1.
  - NORM stops at minimum exponent, producing subnormal results (class subnormal).
  - underflow is set when a tiny result is also inexact.
- Undefined (flush-to-zero):
  - Subnormal inputs are treated as signed zero.
  - Any result below the minimum normal is flushed to signed zero with underflow and inexact set.
  - res_class subnormal is never asserted.

## Test plan
- 0x3F80 + 0x3FC0, op=0, out_ready=1 -> L=3, result 0x4020, class normal, exception 0.
- 0x4000 + 0xBF80 -> k=1, m=1, L=5, result 0x3F80; and 0x3F80 op=1 0x4000 -> 0xBF80.
- 0x7F80 + 0x3F80 -> L=1, 0x7F80, class inf.
- 0x7F81 + 0x3F80 -> 0x7FC0 with invalid.
- 0x7F80 op=1 0x7F80 -> 0x7FC0 with invalid.
- 0x7F7F + 0x7F7F -> 0x7F80, exception overflow|inexact (4'b0101).
- 0x3F80 op=1 0x3F80 -> 0x0000, class zero.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - result, out_valid and in_ready=0 stay stable, and a new in_valid is not accepted.
  - Then out_ready=1 -> in_ready=1 next cycle.
- Reset mid-ALIGN (0x3F80 + 0x3380): assert rst asynchronously.
  - out_valid=0 immediately, with no stale output.
  - The next operation after rst release completes normally.

Source files
------------

// File: rtl/fp_addsub_seq_if.sv
// Operand/result handshake bundle for the sequential bfloat16 add/subtract engine.
// The stimulus side uses master; the engine uses slave.
interface fp_addsub_seq_if #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NEXP+NSIG:0]   a;
  logic [NEXP+NSIG:0]   b;
  logic                 op;
  logic                 out_valid;
  logic                 out_ready;
  logic [NEXP+NSIG:0]   result;
  logic [4:0]           res_class;
  logic [3:0]           exception;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, res_class, exception
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, res_class, exception
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// Iterative bfloat16 add/sub (align/add/norm/round FSM), latency 1 for specials else 3+k+m; result held until accepted.
// FP_SUBNORMAL_EN enables gradual underflow; without it subnormals flush to signed zero.
module fp_addsub_seq #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input logic            clk,
  input logic            rst,
  fp_addsub_seq_if.slave io
);
  localparam int MW = NSIG + 4;
  localparam logic [NEXP-1:0]   E1N  = NEXP'(1);
  localparam logic [NEXP-1:0]   MWN  = NEXP'(MW);
  localparam logic [NEXP:0]     EONE = (NEXP+1)'(1);
  localparam logic [NEXP:0]     EMAX = {1'b0, {NEXP{1'b1}}};
  localparam logic [NEXP+NSIG:0] QNAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  typedef struct packed {
    logic            sgn;
    logic [NEXP-1:0] exp;
    logic [NSIG-1:0] sig;
  } fp_t;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t          state, state_nxt;
  fp_t             ra, rb;
  logic            xs, ys, big;
  logic [MW-1:0]   xm, ym;
  logic [NEXP:0]   e;
  logic [NEXP-1:0] cnt;

  logic                a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, sp, swap;
  logic [NEXP-1:0]     a_e, b_e, diff;
  logic [MW-1:0]       a_m, b_m;
  logic [NEXP+NSIG:0]  sp_res;
  logic [4:0]          sp_cls;
  logic [3:0]          sp_exc;

  // Significand layout: {hidden, fraction, guard, round, sticky}
  always_comb begin
    a_nan  = (&ra.exp) & (|ra.sig);
    b_nan  = (&rb.exp) & (|rb.sig);
    a_inf  = (&ra.exp) & ~(|ra.sig);
    b_inf  = (&rb.exp) & ~(|rb.sig);
    a_snan = a_nan & ~ra.sig[NSIG-1];
    b_snan = b_nan & ~rb.sig[NSIG-1];
    a_e    = (|ra.exp) ? ra.exp : E1N;
    b_e    = (|rb.exp) ? rb.exp : E1N;
`ifdef FP_SUBNORMAL_EN
    a_m = {|ra.exp, ra.sig, 3'b000};
    b_m = {|rb.exp, rb.sig, 3'b000};
`else
    a_m = (|ra.exp) ? {1'b1, ra.sig, 3'b000} : '0;
    b_m = (|rb.exp) ? {1'b1, rb.sig, 3'b000} : '0;
`endif
    swap = b_e > a_e;
    diff = swap ? (b_e - a_e) : (a_e - b_e);
    sp   = a_nan | b_nan | a_inf | b_inf;
    sp_res = QNAN;
    sp_cls = 5'b10000;
    sp_exc = 4'b0000;
    if (a_nan | b_nan) begin
      sp_exc = {a_snan | b_snan, 3'b000};
    end else if (a_inf & b_inf & (ra.sgn != rb.sgn)) begin
      sp_exc = 4'b1000;
    end else if (a_inf) begin
      sp_res = {ra.sgn, {NEXP{1'b1}}, {NSIG{1'b0}}};
      sp_cls = 5'b01000;
    end else begin
      sp_res = {rb.sgn, {NEXP{1'b1}}, {NSIG{1'b0}}};
      sp_cls = 5'b01000;
    end
  end

  logic [MW:0]   sum;
  logic [MW-1:0] add_m, nrm_m;
  logic [NEXP:0] add_e, nrm_e;
  logic          add_s, add_done, nrm_done;

  always_comb begin
    if (xs == ys) begin
      sum   = {1'b0, xm} + {1'b0, ym};
      add_s = xs;
    end else if (xm > ym) begin
      sum   = {1'b0, xm - ym};
      add_s = xs;
    end else if (xm < ym) begin
      sum   = {1'b0, ym - xm};
      add_s = ys;
    end else begin
      sum   = '0;
      add_s = 1'b0;
    end
    if (sum[MW]) begin
      add_m = {sum[MW:2], sum[1] | sum[0]};
      add_e = e + EONE;
    end else begin
      add_m = sum[MW-1:0];
      add_e = e;
    end
    add_done = add_m[MW-1] | ~(|add_m) | (add_e == EONE);
    nrm_m    = {xm[MW-2:0], 1'b0};
    nrm_e    = e - EONE;
    nrm_done = nrm_m[MW-1] | (nrm_e == EONE);
  end

  logic                up, inex, tiny, hb, ovf;
  logic [NSIG+1:0]     rm;
  logic [NEXP:0]       re;
  logic [NSIG-1:0]     frac;
  logic [NEXP-1:0]     expf;
  logic [NEXP+NSIG:0]  rn_res;
  logic [4:0]          rn_cls;
  logic [3:0]          rn_exc;

  always_comb begin
    inex = |xm[2:0];
    up   = xm[2] & (xm[1] | xm[0] | xm[3]);
    tiny = ~xm[MW-1] & (|xm);
    rm   = {1'b0, xm[MW-1:3]} + {{(NSIG+1){1'b0}}, up};
    re   = rm[NSIG+1] ? (e + EONE) : e;
    hb   = rm[NSIG+1] | rm[NSIG];
    frac = rm[NSIG+1] ? '0 : rm[NSIG-1:0];
    // A subnormal that rounds up into the hidden bit becomes normal at exponent 1.
    expf = hb ? re[NEXP-1:0] : '0;
    ovf  = hb & (re >= EMAX);
    rn_res = {xs, expf, frac};
    rn_cls = hb ? 5'b00001 : ((|frac) ? 5'b00010 : 5'b00100);
    rn_exc = {2'b00, tiny & inex, inex};
    if (~(|xm)) begin
      rn_res = {xs, {(NEXP+NSIG){1'b0}}};
      rn_cls = 5'b00100;
      rn_exc = 4'b0000;
    end
`ifndef FP_SUBNORMAL_EN
    else if (tiny) begin
      rn_res = {xs, {(NEXP+NSIG){1'b0}}};
      rn_cls = 5'b00100;
      rn_exc = 4'b0011;
    end
`endif
    else if (ovf) begin
      rn_res = {xs, {NEXP{1'b1}}, {NSIG{1'b0}}};
      rn_cls = 5'b01000;
      rn_exc = 4'b0101;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.in_valid) state_nxt = UNPACK;
      UNPACK:  if (sp) state_nxt = DONE;
               else if (|diff) state_nxt = ALIGN;
               else state_nxt = ADD;
      ALIGN:   if (cnt == E1N) state_nxt = ADD;
      ADD:     state_nxt = add_done ? ROUND : NORM;
      NORM:    if (nrm_done) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign io.in_ready  = (state == IDLE) & ~rst;
  assign io.out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra  <= '0;
      rb  <= '0;
      xs  <= 1'b0;
      ys  <= 1'b0;
      big <= 1'b0;
      xm  <= '0;
      ym  <= '0;
      e   <= '0;
      cnt <= '0;
      io.result    <= '0;
      io.res_class <= '0;
      io.exception <= '0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          ra <= io.a;
          rb <= {io.b[NEXP+NSIG] ^ io.op, io.b[NEXP+NSIG-1:0]};
        end
        UNPACK: if (sp) begin
          io.result    <= sp_res;
          io.res_class <= sp_cls;
          io.exception <= sp_exc;
        end else begin
          // x always carries the larger exponent; only y is ever shifted.
          xs  <= swap ? rb.sgn : ra.sgn;
          ys  <= swap ? ra.sgn : rb.sgn;
          xm  <= swap ? b_m : a_m;
          ym  <= swap ? a_m : b_m;
          e   <= {1'b0, swap ? b_e : a_e};
          big <= diff > MWN;
          cnt <= (diff > MWN) ? MWN : diff;
        end
        ALIGN: begin
          if ((cnt == E1N) && big) ym <= {{(MW-1){1'b0}}, |ym};
          else                     ym <= {1'b0, ym[MW-1:2], ym[1] | ym[0]};
          cnt <= cnt - E1N;
        end
        ADD: begin
          xm <= add_m;
          e  <= add_e;
          xs <= add_s;
        end
        NORM: begin
          xm <= nrm_m;
          e  <= nrm_e;
        end
        ROUND: begin
          io.result    <= rn_res;
          io.res_class <= rn_cls;
          io.exception <= rn_exc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: hand-computed vectors, latency, backpressure and mid-op reset.
// Expectations for tiny results follow the FP_SUBNORMAL_EN build setting.
module tb_fp_addsub_seq;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   lat;
  int   stale;

  fp_addsub_seq_if io ();
  fp_addsub_seq dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb2, input logic top);
    @(negedge clk);
    chk("in_ready_before_op", 32'(io.in_ready), 32'd1);
    io.a = ta;
    io.b = tb2;
    io.op = top;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1 io.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (io.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb2,
                        input logic top, input logic [15:0] eres, input logic [4:0] ecls,
                        input logic [3:0] eexc, input int elat);
    int n;
    start_op(ta, tb2, top);
    wait_out(n);
    chk($sformatf("%s latency", tag), 32'(n), 32'(elat));
    chk($sformatf("%s result", tag), 32'(io.result), 32'(eres));
    chk($sformatf("%s class", tag), 32'(io.res_class), 32'(ecls));
    chk($sformatf("%s exception", tag), 32'(io.exception), 32'(eexc));
    @(posedge clk);
    #1;
    chk($sformatf("%s out_valid_after", tag), 32'(io.out_valid), 32'd0);
    chk($sformatf("%s in_ready_after", tag), 32'(io.in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    io.op = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("rst out_valid", 32'(io.out_valid), 32'd0);
    chk("rst in_ready", 32'(io.in_ready), 32'd0);
    chk("rst result", 32'(io.result), 32'd0);
    chk("rst class", 32'(io.res_class), 32'd0);
    chk("rst exception", 32'(io.exception), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst in_ready", 32'(io.in_ready), 32'd1);

    run_op("add_1p0_1p5", 16'h3F80, 16'h3FC0, 1'b0, 16'h4020, 5'b00001, 4'b0000, 3);
    run_op("add_2_m1",    16'h4000, 16'hBF80, 1'b0, 16'h3F80, 5'b00001, 4'b0000, 5);
    run_op("sub_1_2",     16'h3F80, 16'h4000, 1'b1, 16'hBF80, 5'b00001, 4'b0000, 5);
    run_op("inf_plus_1",  16'h7F80, 16'h3F80, 1'b0, 16'h7F80, 5'b01000, 4'b0000, 1);
    run_op("snan_plus_1", 16'h7F81, 16'h3F80, 1'b0, 16'h7FC0, 5'b10000, 4'b1000, 1);
    run_op("inf_sub_inf", 16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 5'b10000, 4'b1000, 1);
    run_op("max_overflow",16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 5'b01000, 4'b0101, 3);
    run_op("sub_cancel",  16'h3F80, 16'h3F80, 1'b1, 16'h0000, 5'b00100, 4'b0000, 3);
    run_op("sticky_far",  16'h3F80, 16'h3380, 1'b0, 16'h3F80, 5'b00001, 4'b0001, 14);
    run_op("tie_odd_up",  16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 5'b00001, 4'b0001, 11);
    run_op("tie_even_dn", 16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 5'b00001, 4'b0001, 11);
`ifdef FP_SUBNORMAL_EN
    run_op("sub_plus_0",  16'h0001, 16'h0000, 1'b0, 16'h0001, 5'b00010, 4'b0000, 3);
    run_op("tiny_diff",   16'h0081, 16'h0080, 1'b1, 16'h0001, 5'b00010, 4'b0000, 3);
`else
    run_op("sub_plus_0",  16'h0001, 16'h0000, 1'b0, 16'h0000, 5'b00100, 4'b0000, 3);
    run_op("tiny_diff",   16'h0081, 16'h0080, 1'b1, 16'h0000, 5'b00100, 4'b0011, 3);
`endif

    io.out_ready = 1'b0;
    start_op(16'h3F80, 16'h3FC0, 1'b0);
    wait_out(lat);
    chk("bp latency", 32'(lat), 32'd3);
    @(negedge clk);
    io.a = 16'h4000;
    io.b = 16'h4000;
    io.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp hold%0d out_valid", i), 32'(io.out_valid), 32'd1);
      chk($sformatf("bp hold%0d result", i), 32'(io.result), 32'h4020);
      chk($sformatf("bp hold%0d in_ready", i), 32'(io.in_ready), 32'd0);
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release in_ready", 32'(io.in_ready), 32'd1);
    chk("bp release out_valid", 32'(io.out_valid), 32'd0);
    repeat (4) @(posedge clk);
    #1 chk("bp no_extra_op", 32'(io.out_valid), 32'd0);

    start_op(16'h3F80, 16'h3380, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(io.out_valid), 32'd0);
    chk("midrst in_ready", 32'(io.in_ready), 32'd0);
    chk("midrst result", 32'(io.result), 32'd0);
    chk("midrst exception", 32'(io.exception), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (16) begin
      @(posedge clk);
      #1 if (io.out_valid === 1'b1) stale++;
    end
    chk("midrst stale_output", 32'(stale), 32'd0);
    run_op("after_rst", 16'h4000, 16'hBF80, 1'b0, 16'h3F80, 5'b00001, 4'b0000, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
